// File: rtl/led_hold_pwm.sv
// Purpose : holds each 3-bit LED sample from the pattern generator for HOLD_CYCLES cycles, with PWM gating.
// Latency : sample accepted at edge E0 into an idle, empty block first appears on led_out after E2.
// Backpr. : in_ready = !full (registered count, no pass-through); offers made while full are dropped and counted.
//
// Ports:
//   clk       single clock, posedge
//   reset     asynchronous, active-low; clears all state
//   in_valid  in_led carries a sample
//   in_led    [2] bar, [1] mosca, [0] azul
//   in_ready  FIFO can accept a sample
//   duty      PWM brightness level (all-ones = always on, 0 = always off)
//   led_out   registered LED drive, same bit order as in_led
//   busy      FSM showing a sample or FIFO non-empty
//   drop_cnt  saturating count of rejected offers
//
// Build option: define LED_PWM_EN to include the PWM counter and gating;
// without it duty is ignored and led_out shows the held sample ungated.
module led_hold_pwm #(
   parameter int HOLD_CYCLES = 4,
   parameter int DEPTH       = 4,
   parameter int PWM_BITS    = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [2:0]          in_led,
   output logic                in_ready,
   input  logic [PWM_BITS-1:0] duty,
   output logic [2:0]          led_out,
   output logic                busy,
   output logic [7:0]          drop_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic {IDLE, SHOW} state_t;

   logic [2:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    drop_q, drop_d;
   state_t        state_q;
   logic [2:0]    cur_q;
   logic [HW-1:0] hold_q;
   logic [2:0]    led_q;
   logic          full, empty, push, pop, gate;
   logic [2:0]    rd_dat;

   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign push   = in_valid && !full;
   // Pop decisions use the pre-edge count; IDLE pops on any non-empty FIFO,
   // SHOW only when the current sample has finished its hold.
   assign pop    = !empty && ((state_q == IDLE) || (hold_q == '0));
   assign rd_dat = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push)
         count_d = count_q - CW'(1);
   end

   always_comb begin
      drop_d = drop_q;
      if (in_valid && full && (drop_q != 8'hFF))
         drop_d = drop_q + 8'd1;
   end

   // Storage has no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= in_led;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         drop_q  <= drop_d;
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pwm_cnt_q <= '0;
      else
         pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
   end

   // Full-scale duty must be solidly on; the compare alone would leave one dark slot.
   assign gate = (&duty) || (pwm_cnt_q < duty);
`else
   logic unused_duty;
   assign unused_duty = ^duty;
   assign gate        = 1'b1;
`endif

   // Display FSM. led_q is built from pre-edge state, so it trails the FSM by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cur_q   <= '0;
         hold_q  <= '0;
         led_q   <= '0;
      end else begin
         led_q <= (state_q == SHOW) ? (cur_q & {3{gate}}) : 3'b000;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  cur_q   <= rd_dat;
                  hold_q  <= HW'(HOLD_CYCLES - 1);
                  state_q <= SHOW;
               end
            end
            SHOW: begin
               if (hold_q != '0) begin
                  hold_q <= hold_q - HW'(1);
               end else if (pop) begin
                  // Reload straight away so consecutive samples abut.
                  cur_q  <= rd_dat;
                  hold_q <= HW'(HOLD_CYCLES - 1);
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready = !full;
   assign led_out  = led_q;
   assign busy     = (state_q == SHOW) || !empty;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_led_hold_pwm.sv
// Self-checking bench for led_hold_pwm (HOLD_CYCLES=4, DEPTH=4, PWM_BITS=3).
// Stimulus queues each sample expected on led_out; a negedge monitor pops the
// queue at the start of every display run and checks value and run length.
module tb_led_hold_pwm;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [2:0] in_led = 3'b000;
   logic [2:0] duty = 3'd7;
   logic       in_ready;
   logic [2:0] led_out;
   logic       busy;
   logic [7:0] drop_cnt;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [2:0] sb [$];
   bit         mon_en = 1'b0;
   int         run_len = 0;
   logic [2:0] exp_cur = 3'b000;

   led_hold_pwm #(
      .HOLD_CYCLES(HOLD),
      .DEPTH      (4),
      .PWM_BITS   (3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in_valid(in_valid),
      .in_led  (in_led),
      .in_ready(in_ready),
      .duty    (duty),
      .led_out (led_out),
      .busy    (busy),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Scoreboard monitor: every non-zero led_out cycle belongs to a run of HOLD cycles.
   always @(negedge clk) begin
      if (!reset) begin
         run_len = 0;
      end else if (mon_en) begin
         if (led_out != 3'b000) begin
            if (run_len == 0) begin
               if (sb.size() == 0)
                  chk("sb_unexpected_sample", int'(led_out), 0);
               else
                  exp_cur = sb.pop_front();
            end
            chk("sb_led_value", int'(led_out), int'(exp_cur));
            run_len++;
            if (run_len == HOLD)
               run_len = 0;
         end else if (run_len != 0) begin
            chk("sb_hold_length", run_len, HOLD);
            run_len = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [2:0] seq [3];
      logic [2:0] ovf [6];
      int         exp_led;
      seq = '{3'b100, 3'b010, 3'b001};
      ovf = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

      // Reset state while reset is held low from time 0
      #2;
      chk("rst_led_out", int'(led_out), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);

      // Single sample 101, duty=7
      do_reset();
      duty = 3'd7;
      mon_en = 1'b1;
      in_valid = 1'b1; in_led = 3'b101;
      sb.push_back(3'b101);
      step();                                   // E0
      in_valid = 1'b0;
      chk("single_busy_after_push", int'(busy), 1);
      step();                                   // E1
      chk("single_led_E1", int'(led_out), 0);
      step();                                   // E2
      chk("single_led_E2", int'(led_out), 5);
      repeat (3) step();                        // E5
      chk("single_led_E5", int'(led_out), 5);
      chk("single_busy_idle", int'(busy), 0);
      step();                                   // E6
      chk("single_led_E6", int'(led_out), 0);
      repeat (3) step();
      chk("single_sb_drained", sb.size(), 0);

      // Back-to-back 100, 010, 001: 12 contiguous cycles
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_led = seq[i];
         sb.push_back(seq[i]);
         step();                                // E0..E2
      end
      in_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) step();                     // E2..E13
         chk("b2b_led_cycle", int'(led_out), int'(seq[k / 4]));
      end
      step();                                   // E14
      chk("b2b_led_after", int'(led_out), 0);
      chk("b2b_drop_cnt", int'(drop_cnt), 0);
      repeat (3) step();
      chk("b2b_sb_drained", sb.size(), 0);

      // Overflow: A..E fill FIFO plus cur, F offered while full
      do_reset();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_led = ovf[i];
         if (i < 5) sb.push_back(ovf[i]);
         step();                                // E0..E5
         if (i == 3) chk("ovf_ready_E3", int'(in_ready), 1);
         if (i == 4) chk("ovf_ready_E4", int'(in_ready), 0);
         if (i == 5) chk("ovf_drop_E5", int'(drop_cnt), 1);
      end
      in_valid = 1'b0;
      repeat (24) step();
      chk("ovf_sb_drained", sb.size(), 0);
      chk("ovf_led_idle", int'(led_out), 0);
      chk("ovf_busy_idle", int'(busy), 0);
      chk("ovf_drop_final", int'(drop_cnt), 1);

      // PWM: five 111 samples, duty 3 then 0 then 7
      mon_en = 1'b0;
      do_reset();
      duty = 3'd3;
      for (int k = 0; k < 18; k++) begin
         in_valid = (k < 5);
         in_led   = 3'b111;
         if (k == 10) duty = 3'd0;
         if (k == 14) duty = 3'd7;
         step();                                // Ek
`ifdef LED_PWM_EN
         if (k < 10)      exp_led = ((k % 8) < 3) ? 7 : 0;
         else if (k < 14) exp_led = 0;
         else             exp_led = 7;
`else
         exp_led = 7;
`endif
         if (k >= 2) chk("pwm_led_cycle", int'(led_out), exp_led);
      end
      in_valid = 1'b0;
      repeat (6) step();

      // Saturation: continuous offers keep the FIFO full
      do_reset();
      duty = 3'd7;
      in_valid = 1'b1; in_led = 3'b111;
      repeat (420) step();
      chk("sat_drop_255", int'(drop_cnt), 255);
      repeat (40) step();
      chk("sat_drop_holds", int'(drop_cnt), 255);
      chk("sat_led_showing", int'(led_out), 7);

      // Asynchronous reset between edges, mid-SHOW, FIFO full
      in_valid = 1'b0;
      #3 reset = 1'b0;
      #1;
      chk("arst_led_out", int'(led_out), 0);
      chk("arst_in_ready", int'(in_ready), 1);
      chk("arst_busy", int'(busy), 0);
      chk("arst_drop_cnt", int'(drop_cnt), 0);
      sb.delete();
      #2 reset = 1'b1;
      mon_en = 1'b1;
      repeat (20) step();
      chk("arst_no_stale_led", int'(led_out), 0);
      chk("arst_no_stale_busy", int'(busy), 0);
      chk("arst_drop_after", int'(drop_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
